// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 64-point FFT output path.
package fft_pkg;

  localparam int N          = 64;
  localparam int LOG2N      = 6;
  localparam int NBEAT      = 32;
  localparam int DW_DEFAULT = 16;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_mem.sv
// Ping-pong sample store: two 64-entry halves, dual write port, async read port.
module fft_reorder_mem
  import fft_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wbuf,
  input  logic [LOG2N-1:0] addr_a,
  input  logic [DW-1:0]    a_re,
  input  logic [DW-1:0]    a_im,
  input  logic [LOG2N-1:0] addr_b,
  input  logic [DW-1:0]    b_re,
  input  logic [DW-1:0]    b_im,
  input  logic             rbuf,
  input  logic [LOG2N-1:0] raddr,
  output logic [DW-1:0]    rd_re,
  output logic [DW-1:0]    rd_im
);

  logic [2*DW-1:0] mem [0:2*N-1];

  // Lanes A and B always land in opposite halves of the index space, so never collide.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wbuf, addr_a}] <= {a_re, a_im};
      mem[{wbuf, addr_b}] <= {b_re, b_im};
    end
  end

  assign {rd_re, rd_im} = mem[{rbuf, raddr}];

endmodule

// File: rtl/fft_output_reorder.sv
// Reorders the two-lane bit-reversed FFT output into a natural-order
// valid/ready stream through a ping-pong buffer.
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [DW-1:0] in_a_re,
  input  logic [DW-1:0] in_a_im,
  input  logic [DW-1:0] in_b_re,
  input  logic [DW-1:0] in_b_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic [5:0]    out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);

  wstate_t    state, state_next;
  logic [4:0] wcnt, wcnt_next;
  logic [4:0] wr_beat;
  logic       wbuf, rbuf;
  logic [5:0] rcnt;
  logic [1:0] count, count_next;
  logic       start, load, rel, can_accept;
  logic       we, fill_done, set_ovf;
  logic [5:0] waddr_a, waddr_b;
  logic [DW-1:0] rd_re, rd_im;

  assign start      = in_valid & in_first;
  assign load       = (count != 2'd0) & (~out_valid | out_ready);
  assign rel        = load & (rcnt == 6'(N-1));
  // A buffer being released this very cycle counts as free for a new frame.
  assign can_accept = (count != 2'd2) | rel;
  assign waddr_a    = bitrev6({wr_beat, 1'b0});
  assign waddr_b    = {1'b1, waddr_a[4:0]};

  // Write-side next state: frame start, fill progress and drop counting.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    wr_beat    = wcnt;
    we         = 1'b0;
    fill_done  = 1'b0;
    set_ovf    = 1'b0;
    if (start) begin
      if (can_accept) begin
        state_next = W_FILL;
        wcnt_next  = 5'd1;
        wr_beat    = 5'd0;
        we         = 1'b1;
      end else begin
        state_next = W_DROP;
        wcnt_next  = 5'd1;
        set_ovf    = 1'b1;
      end
    end else if (in_valid) begin
      case (state)
        W_FILL: begin
          we = 1'b1;
          if (wcnt == 5'(NBEAT-1)) begin
            fill_done  = 1'b1;
            state_next = W_IDLE;
            wcnt_next  = 5'd0;
          end else begin
            wcnt_next = wcnt + 5'd1;
          end
        end
        W_DROP: begin
          if (wcnt == 5'(NBEAT-1)) begin
            state_next = W_IDLE;
            wcnt_next  = 5'd0;
          end else begin
            wcnt_next = wcnt + 5'd1;
          end
        end
        W_IDLE: begin
          state_next = W_IDLE;
        end
        default: begin
          state_next = W_IDLE;
          wcnt_next  = 5'd0;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // Occupancy update; a simultaneous fill and release cancel out.
  always_comb begin
    case ({fill_done, rel})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Write-side and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= W_IDLE;
      wcnt     <= 5'd0;
      wbuf     <= 1'b0;
      rbuf     <= 1'b0;
      count    <= 2'd0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      count <= count_next;
      busy  <= (state_next == W_FILL) | (count_next != 2'd0);
      if (fill_done) wbuf <= ~wbuf;
      if (rel) rbuf <= ~rbuf;
      if (set_ovf) overflow <= 1'b1;
    end
  end

  // Output register: loads when empty or accepted, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= 6'd0;
      out_last  <= 1'b0;
      rcnt      <= 6'd0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_re    <= rd_re;
      out_im    <= rd_im;
      out_idx   <= rcnt;
      out_last  <= (rcnt == 6'(N-1));
      rcnt      <= rcnt + 6'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  fft_reorder_mem #(.DW(DW)) u_mem (
    .clk    (clk),
    .we     (we),
    .wbuf   (wbuf),
    .addr_a (waddr_a),
    .a_re   (in_a_re),
    .a_im   (in_a_im),
    .addr_b (waddr_b),
    .b_re   (in_b_re),
    .b_im   (in_b_im),
    .rbuf   (rbuf),
    .raddr  (rcnt),
    .rd_re  (rd_re),
    .rd_im  (rd_im)
  );

endmodule

// File: tb/tb_fft_output_reorder.sv
// Self-checking bench for fft_output_reorder: frames in bit-reversed two-lane
// order, outputs compared against a natural-order expectation queue.
module tb_fft_output_reorder;

  localparam int DW = 16;
  typedef logic [6+1+2*DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_first;
  logic [DW-1:0] in_a_re, in_a_im, in_b_re, in_b_im;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_re, out_im;
  logic [5:0]    out_idx;
  logic          out_last, busy, overflow;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  logic [DW-1:0] fre [64];
  logic [DW-1:0] fim [64];
  ent_t exp_q [$];
  ent_t cap_q [$];
  int   cap_t [$];

  fft_output_reorder #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output sample with the cycle it was accepted in.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      cap_q.push_back({out_idx, out_last, out_re, out_im});
      cap_t.push_back(cyc);
    end
  end

  function automatic int tb_bitrev(input int x);
    int r = 0;
    for (int i = 0; i < 6; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  function automatic ent_t mk(input int idx, input logic [DW-1:0] re, input logic [DW-1:0] im);
    logic last;
    last = (idx == 63);
    return {6'(idx), last, re, im};
  endfunction

  task automatic gen_frame(input int mode, input int base);
    for (int n = 0; n < 64; n++) begin
      if (mode == 0) begin
        fre[n] = DW'(base + n);
        fim[n] = DW'(-(base + n));
      end else begin
        fre[n] = DW'($urandom);
        fim[n] = DW'($urandom);
      end
    end
  endtask

  task automatic push_exp();
    for (int n = 0; n < 64; n++) exp_q.push_back(mk(n, fre[n], fim[n]));
  endtask

  task automatic drive_frame(input int nbeats, input bit with_first);
    int a;
    for (int k = 0; k < nbeats; k++) begin
      a = tb_bitrev(2 * k);
      in_valid = 1'b1;
      in_first = with_first && (k == 0);
      in_a_re = fre[a];      in_a_im = fim[a];
      in_b_re = fre[a + 32]; in_b_im = fim[a + 32];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget);
    for (int i = 0; i < budget && cap_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); cap_q.delete(); cap_t.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_first = 1'b1; out_ready = 1'b1;
    in_a_re = 16'h1234; in_a_im = 16'h5678; in_b_re = 16'h9abc; in_b_im = 16'hdef0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0;
    tests_run++;
    if ({out_valid, out_last, out_idx, out_re, out_im, busy, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state got v=%b l=%b idx=%0d re=%h im=%h busy=%b ovf=%b want all 0",
               out_valid, out_last, out_idx, out_re, out_im, busy, overflow);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle got v=%b busy=%b want 0 0", out_valid, busy);
    end
    exp_q.delete(); cap_q.delete(); cap_t.delete();
  endtask

  task automatic test_single_frame();
    do_reset();
    out_ready = 1'b1;
    gen_frame(0, 0);
    push_exp();
    drive_frame(32, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_lat1 got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b1 || out_idx !== 6'd0) begin
      fails++;
      $display("FAIL single_lat2 got v=%b idx=%0d want v=1 idx=0", out_valid, out_idx);
    end
    wait_caps(64, 200);
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (cap_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL single_count got %0d want %0d", cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests_run++;
      if (cap_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL single_data[%0d] got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (busy !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_end got busy=%b ovf=%b v=%b want 0 0 0", busy, overflow, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    gen_frame(0, 0);   push_exp(); drive_frame(32, 1'b1);
    gen_frame(0, 100); push_exp(); drive_frame(32, 1'b1);
    wait_caps(128, 300);
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (cap_q.size() != 128) begin
      fails++;
      $display("FAIL b2b_count got %0d want 128", cap_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests_run++;
      if (cap_q[i] !== exp_q[i] || cap_t[i] != cap_t[0] + i) begin
        fails++;
        $display("FAIL b2b_data[%0d] got %h at cyc %0d want %h at cyc %0d",
                 i, cap_q[i], cap_t[i], exp_q[i], cap_t[0] + i);
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_overflow got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    gen_frame(1, 0); push_exp(); drive_frame(32, 1'b1);
    gen_frame(1, 0); push_exp(); drive_frame(32, 1'b1);
    tests_run++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ovf_two_frames got ovf=%b busy=%b want 0 1", overflow, busy);
    end
    gen_frame(1, 0); drive_frame(32, 1'b1);
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_third_frame got ovf=%b want 1", overflow);
    end
    out_ready = 1'b1;
    wait_caps(128, 400);
    repeat (80) @(posedge clk);
    #1;
    tests_run++;
    if (cap_q.size() != 128) begin
      fails++;
      $display("FAIL ovf_count got %0d want 128", cap_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests_run++;
      if (cap_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ovf_data[%0d] got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ovf_sticky got ovf=%b busy=%b want 1 0", overflow, busy);
    end
  endtask

  task automatic test_stall();
    logic prev_stall;
    ent_t prev_e, cur;
    do_reset();
    out_ready = 1'b0;
    gen_frame(1, 0); push_exp(); drive_frame(32, 1'b1);
    prev_stall = 1'b0;
    prev_e = '0;
    for (int i = 0; i < 300 && cap_q.size() < 64; i++) begin
      out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      @(negedge clk);
      cur = {out_idx, out_last, out_re, out_im};
      if (prev_stall) begin
        tests_run++;
        if (out_valid !== 1'b1 || cur !== prev_e) begin
          fails++;
          $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, cur, prev_e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_e = cur;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (cap_q.size() != 64) begin
      fails++;
      $display("FAIL stall_count got %0d want 64", cap_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests_run++;
      if (cap_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stall_data[%0d] got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abandon_and_reset();
    do_reset();
    out_ready = 1'b1;
    gen_frame(1, 0); drive_frame(10, 1'b1);
    gen_frame(1, 0); push_exp(); drive_frame(32, 1'b1);
    wait_caps(64, 200);
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (cap_q.size() != 64) begin
      fails++;
      $display("FAIL abandon_count got %0d want 64", cap_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests_run++;
      if (cap_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL abandon_data[%0d] got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
    gen_frame(1, 0); drive_frame(32, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL middrain_rst got v=%b busy=%b want 0 0", out_valid, busy);
    end
    rst = 1'b0;
    cap_q.delete(); cap_t.delete();
    gen_frame(1, 0); drive_frame(32, 1'b0);
    repeat (80) @(posedge clk);
    #1;
    tests_run++;
    if (cap_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL no_first got %0d outputs busy=%b want 0 0", cap_q.size(), busy);
    end
  endtask

  task automatic test_release_same_cycle();
    bit found;
    do_reset();
    out_ready = 1'b0;
    gen_frame(1, 0); push_exp(); drive_frame(32, 1'b1);
    gen_frame(1, 0); push_exp(); drive_frame(32, 1'b1);
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == 6'd62) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      fails++;
      $display("FAIL release_wait got no idx 62 within bound want idx 62");
    end
    gen_frame(1, 0); push_exp(); drive_frame(32, 1'b1);
    tests_run++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL release_overflow got %b want 0", overflow);
    end
    wait_caps(192, 400);
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (cap_q.size() != 192) begin
      fails++;
      $display("FAIL release_count got %0d want 192", cap_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      tests_run++;
      if (cap_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL release_data[%0d] got %h want %h", i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_abandon_and_reset();
    test_release_same_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/fft_output_reorder.md
# fft_output_reorder

Downstream of the 64-point radix-2 DIF FFT control/datapath, after the final stage. Takes the two-lane, bit-reversed-order stream produced during the last FFT stage: 32 beats, each carrying two complex bins. Writes each frame into one half of a ping-pong buffer at natural-order addresses, then drains it as a one-sample-per-cycle, natural-order stream under a valid/ready handshake.

## Interface
Parameters:
- DW, 16, width of each real/imag component (two's complement, passed through unmodified)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat present; no backpressure
- in_first  in  1  marks beat 0 of a frame; qualified by in_valid
- in_a_re, in_a_im  in  DW  lane A sample
- in_b_re, in_b_im  in  DW  lane B sample
- out_valid  out  1  output sample present
- out_ready  in  1  downstream accepts
- out_re, out_im  out  DW  output sample
- out_idx  out  6  natural frequency index of the output sample
- out_last  out  1  high with out_idx==63
- busy  out  1  a fill is in progress or at least one buffer is full
- overflow  out  1  sticky; a frame was dropped

## Operation
- Frame input ordering:
  - Beat k (0..31) lane A carries X[bitrev6(2k)].
  - Lane B carries X[bitrev6(2k+1)], which equals bitrev6(2k) + 32.
  - Each beat writes mem[wbuf][bitrev6(2k)] = A and mem[wbuf][bitrev6(2k)+32] = B in the same cycle.
- Write FSM states:
  - IDLE → FILL on in_valid&in_first when a buffer is free. The beat counter wcnt restarts at 0, and that beat is written as beat 0.
  - FILL: each in_valid beat writes, then wcnt++. After beat 31: mark wbuf full, toggle wbuf, return to IDLE.
  - DROP: entered on in_valid&in_first when both buffers are full and none is released that cycle. Sets overflow. Ignores 32 beats, then returns to IDLE.
- In IDLE, in_valid without in_first is ignored.
- in_first during FILL or DROP:
  - Abandons the current frame; the partial buffer stays not-full.
  - The new frame is then handled as if arriving in IDLE: accepted or dropped.
- Read side:
  - When rbuf is full and (!out_valid | out_ready), the output register loads mem[rbuf][rcnt], out_idx=rcnt, out_last=(rcnt==63), and rcnt++.
  - The load with rcnt==63 frees rbuf, toggles rbuf, and wraps rcnt to 0.
- Output holds while out_valid & !out_ready: data, idx and last are stable.
- Occupancy count 0..2 is tracked explicitly. A completing fill and a freeing read in the same cycle leave the count unchanged. A free in the same cycle as in_first (count==2) makes the frame accepted, not dropped.
- The write side never targets a full buffer; the read side never reads a non-full buffer.
- Data is stored bit-exact; no scaling, no rounding.

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_idx=0, out_re=out_im=0, busy=0, overflow=0.
  - wbuf=rbuf=0, wcnt=rcnt=0, count=0, write FSM in IDLE.
  - Memory contents are not reset.
- rst mid-frame or mid-drain: partial and stored frames are discarded; the next frame needs in_first.
- Latency: final beat (k=31) sampled in cycle c → out_valid=1 with out_idx=0 in cycle c+2, provided rbuf was previously empty.
- With out_ready held high: 64 consecutive out_valid cycles, idx 0..63.
- Input frame spacing may be as short as 32 back-to-back beats (new in_first the cycle after beat 31). Two frames buffer without loss.

## Structure
- Shared package fft_pkg:
  - N=64, LOG2N=6, NBEAT=32.
  - bitrev6 function.
  - Component type for a DW-wide signed re/im pair.
- Sub-module fft_reorder_mem:
  - 2×64 entries of {re,im}, register array.
  - Two write ports (A, B; never the same address in one cycle).
  - One asynchronous read port feeding the output register.
- Top level holds the write FSM, read counter, occupancy and handshake.

## Test plan
- Single frame, X[n]=n (re=n, im=-n), driven in bit-reversed two-lane order, out_ready=1 → out_idx/out_re sequence 0..63, out_im 0..-63, out_last only at idx 63, first out_valid exactly 2 cycles after beat 31.
- Back-to-back frames F0 (re=n), F1 (re=100+n), out_ready=1 → 128 contiguous natural-order outputs, overflow=0.
- Three back-to-back frames with out_ready=0 → F2 dropped, overflow=1; release ready → F0 then F1 only.
- out_ready toggled 1,0,0,1 repeatedly → no duplicate or skipped idx; data stable while stalled.
- in_first at beat 10 of a frame, then a full new frame → only the new frame is output; assert rst mid-drain → out_valid=0 next cycle, busy=0.
- Release (idx 63 accepted) in the same cycle as in_first with count==2 → frame accepted, overflow stays 0.
